// File: rtl/replace_policy_unit.sv
// Replacement-policy victim selector for a set-associative cache.
// Keeps per-set LRU ages and FIFO pointers for every set, plus a shared
// LFSR, and picks the way to access (hit) or replace (miss) under the
// LRU, FIFO or pseudo-random policy chosen per request by mode_i.
//
// Ports:
//   clk_i, rst_ni         clock, asynchronous active-low reset
//   mode_i                0 = LRU, 1 = FIFO, 2 = random, 3 = LRU
//   req_valid_i/ready_o   lookup handshake (one lookup per cycle)
//   req_set_i             set index
//   req_valid_line_i      per-way valid bits of the addressed set
//   req_hit_line_i        per-way hit bits (all zero = miss)
//   resp_valid_o          strobe, high the cycle after acceptance
//   resp_line_o           one-hot chosen way
//   resp_hit_o            response belongs to a hit
//   flush_i               start restoring all replacement state
//   flush_busy_o          flush walk in progress
module replace_policy_unit #(
    parameter int unsigned SET_NUM   = 16,
    parameter int unsigned SET_SIZE  = 4,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic [1:0]                 mode_i,
    input  logic                       req_valid_i,
    output logic                       req_ready_o,
    input  logic [$clog2(SET_NUM)-1:0] req_set_i,
    input  logic [SET_SIZE-1:0]        req_valid_line_i,
    input  logic [SET_SIZE-1:0]        req_hit_line_i,
    output logic                       resp_valid_o,
    output logic [SET_SIZE-1:0]        resp_line_o,
    output logic                       resp_hit_o,
    input  logic                       flush_i,
    output logic                       flush_busy_o
);

    localparam int unsigned AW = $clog2(SET_SIZE);
    localparam int unsigned SW = $clog2(SET_NUM);

    typedef enum logic [0:0] {S_IDLE, S_FLUSH} state_e;

    state_e          state_q, state_d;
    logic [SW-1:0]   flush_cnt_q, flush_cnt_d;
    logic [15:0]     lfsr_q;
    logic [AW-1:0]   age_q [SET_NUM][SET_SIZE];
    logic [AW-1:0]   fifo_ptr_q [SET_NUM];
    logic            resp_valid_q;
    logic [SET_SIZE-1:0] resp_line_q;
    logic            resp_hit_q;

    logic            accept;
    logic            hit_any;
    logic            all_valid;
    logic            found;
    logic [AW-1:0]   chosen_idx;
    logic [AW-1:0]   age_sel;
    logic [AW-1:0]   age_new [SET_SIZE];
    logic            fifo_adv;

    assign req_ready_o  = (state_q == S_IDLE) & ~flush_i;
    assign accept       = req_valid_i & req_ready_o;
    assign flush_busy_o = (state_q == S_FLUSH);
    assign resp_valid_o = resp_valid_q;
    assign resp_line_o  = resp_line_q;
    assign resp_hit_o   = resp_hit_q;

    // Victim / hit-way selection: hit > lowest invalid > policy choice.
    always_comb begin
        hit_any    = |req_hit_line_i;
        all_valid  = &req_valid_line_i;
        chosen_idx = '0;
        found      = 1'b0;
        if (hit_any) begin
            for (int unsigned w = 0; w < SET_SIZE; w++) begin
                if (!found && req_hit_line_i[w]) begin
                    chosen_idx = AW'(w);
                    found      = 1'b1;
                end
            end
        end else if (!all_valid) begin
            for (int unsigned w = 0; w < SET_SIZE; w++) begin
                if (!found && !req_valid_line_i[w]) begin
                    chosen_idx = AW'(w);
                    found      = 1'b1;
                end
            end
        end else begin
            case (mode_i)
                2'd1: chosen_idx = fifo_ptr_q[req_set_i];
                2'd2: chosen_idx = lfsr_q[AW-1:0];
                default: begin
                    for (int unsigned w = 0; w < SET_SIZE; w++) begin
                        if (age_q[req_set_i][w] == AW'(SET_SIZE - 1)) begin
                            chosen_idx = AW'(w);
                        end
                    end
                end
            endcase
        end
    end

    // Ages younger than the chosen way's age each get one step older.
    always_comb begin
        age_sel = age_q[req_set_i][chosen_idx];
        for (int unsigned w = 0; w < SET_SIZE; w++) begin
            age_new[w] = age_q[req_set_i][w];
            if (AW'(w) == chosen_idx) begin
                age_new[w] = '0;
            end else if (age_q[req_set_i][w] < age_sel) begin
                age_new[w] = age_q[req_set_i][w] + AW'(1);
            end
        end
        fifo_adv = !hit_any && all_valid && (chosen_idx == fifo_ptr_q[req_set_i]);
    end

    // Flush walk: one set per cycle, SET_NUM cycles total.
    always_comb begin
        state_d     = state_q;
        flush_cnt_d = flush_cnt_q;
        case (state_q)
            S_IDLE: begin
                if (flush_i) begin
                    state_d     = S_FLUSH;
                    flush_cnt_d = '0;
                end
            end
            S_FLUSH: begin
                flush_cnt_d = flush_cnt_q + SW'(1);
                if (flush_cnt_q == SW'(SET_NUM - 1)) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= S_IDLE;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    // Fibonacci LFSR x^16+x^14+x^13+x^11+1, free-running.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
        end
    end

    // Per-set replacement state; accept and flush never coincide.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned s = 0; s < SET_NUM; s++) begin
                fifo_ptr_q[s] <= '0;
                for (int unsigned w = 0; w < SET_SIZE; w++) begin
                    age_q[s][w] <= AW'(w);
                end
            end
        end else if (state_q == S_FLUSH) begin
            fifo_ptr_q[flush_cnt_q] <= '0;
            for (int unsigned w = 0; w < SET_SIZE; w++) begin
                age_q[flush_cnt_q][w] <= AW'(w);
            end
        end else if (accept) begin
            for (int unsigned w = 0; w < SET_SIZE; w++) begin
                age_q[req_set_i][w] <= age_new[w];
            end
            if (fifo_adv) begin
                fifo_ptr_q[req_set_i] <= fifo_ptr_q[req_set_i] + AW'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            resp_valid_q <= 1'b0;
            resp_line_q  <= '0;
            resp_hit_q   <= 1'b0;
        end else begin
            resp_valid_q <= accept;
            resp_line_q  <= accept ? (SET_SIZE'(1) << chosen_idx) : '0;
            resp_hit_q   <= accept & hit_any;
        end
    end

endmodule

// File: tb/tb_replace_policy_unit.sv
// Directed bench for replace_policy_unit (4 sets x 4 ways).
module tb_replace_policy_unit;

    logic       clk_i;
    logic       rst_ni;
    logic [1:0] mode_i;
    logic       req_valid_i;
    logic       req_ready_o;
    logic [1:0] req_set_i;
    logic [3:0] req_valid_line_i;
    logic [3:0] req_hit_line_i;
    logic       resp_valid_o;
    logic [3:0] resp_line_o;
    logic       resp_hit_o;
    logic       flush_i;
    logic       flush_busy_o;

    int checks   = 0;
    int failures = 0;

    replace_policy_unit #(
        .SET_NUM  (4),
        .SET_SIZE (4),
        .LFSR_SEED(16'hACE1)
    ) dut (
        .clk_i           (clk_i),
        .rst_ni          (rst_ni),
        .mode_i          (mode_i),
        .req_valid_i     (req_valid_i),
        .req_ready_o     (req_ready_o),
        .req_set_i       (req_set_i),
        .req_valid_line_i(req_valid_line_i),
        .req_hit_line_i  (req_hit_line_i),
        .resp_valid_o    (resp_valid_o),
        .resp_line_o     (resp_line_o),
        .resp_hit_o      (resp_hit_o),
        .flush_i         (flush_i),
        .flush_busy_o    (flush_busy_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [1:0] set;
        logic [3:0] vl;
        logic [3:0] hl;
        logic [1:0] mode;
        logic [3:0] line;
        logic       hit;
    } vec_t;

    vec_t vecs [11];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return {v[0] ^ v[2] ^ v[3] ^ v[5], v[15:1]};
    endfunction

    task automatic do_reset();
        @(negedge clk_i);
        rst_ni = 1'b0;
        #2;
        chk("rst_resp_valid", int'(resp_valid_o), 0);
        chk("rst_resp_line", int'(resp_line_o), 0);
        chk("rst_resp_hit", int'(resp_hit_o), 0);
        chk("rst_flush_busy", int'(flush_busy_o), 0);
        chk("rst_ready", int'(req_ready_o), 1);
        @(negedge clk_i);
        rst_ni = 1'b1;
    endtask

    task automatic one_req(input string name, input logic [1:0] set, input logic [3:0] vl,
                           input logic [3:0] hl, input logic [1:0] mode,
                           input logic [3:0] exp_line, input logic exp_hit);
        @(negedge clk_i);
        req_set_i        = set;
        req_valid_line_i = vl;
        req_hit_line_i   = hl;
        mode_i           = mode;
        req_valid_i      = 1'b1;
        @(posedge clk_i);
        #1;
        req_valid_i = 1'b0;
        chk({name, "_valid"}, int'(resp_valid_o), 1);
        chk({name, "_line"}, int'(resp_line_o), int'(exp_line));
        chk({name, "_hit"}, int'(resp_hit_o), int'(exp_hit));
    endtask

    initial begin
        logic [15:0] model;
        logic [3:0]  fifo_exp [5];

        rst_ni = 1'b0; mode_i = 2'd0; req_valid_i = 1'b0; req_set_i = '0;
        req_valid_line_i = '0; req_hit_line_i = '0; flush_i = 1'b0;

        // Random: request pending across reset release, first edge uses seed.
        do_reset();
        @(negedge clk_i);
        rst_ni = 1'b0;
        req_set_i = 2'd3; req_valid_line_i = 4'hF; req_hit_line_i = 4'h0;
        mode_i = 2'd2; req_valid_i = 1'b1;
        #1;
        rst_ni = 1'b1;
        model = 16'hACE1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk_i);
            #1;
            if (i == 4) req_valid_i = 1'b0;
            chk($sformatf("rand%0d_valid", i), int'(resp_valid_o), 1);
            chk($sformatf("rand%0d_line", i), int'(resp_line_o), 1 << model[1:0]);
            if (i == 0) chk("rand_first_seed", int'(resp_line_o), 4'b0010);
            model = lfsr_step(model);
        end

        // Table-driven LRU / invalid-fill / hit cases from a fresh reset.
        vecs[0]  = '{2'd0, 4'hF, 4'h0, 2'd0, 4'b1000, 1'b0};
        vecs[1]  = '{2'd0, 4'hF, 4'h0, 2'd0, 4'b0100, 1'b0};
        vecs[2]  = '{2'd1, 4'hF, 4'b0100, 2'd0, 4'b0100, 1'b1};
        vecs[3]  = '{2'd1, 4'hF, 4'h0, 2'd0, 4'b1000, 1'b0};
        vecs[4]  = '{2'd0, 4'hF, 4'h0, 2'd0, 4'b0010, 1'b0};
        vecs[5]  = '{2'd3, 4'b1011, 4'h0, 2'd0, 4'b0100, 1'b0};
        vecs[6]  = '{2'd3, 4'b1011, 4'h0, 2'd1, 4'b0100, 1'b0};
        vecs[7]  = '{2'd3, 4'b1011, 4'h0, 2'd2, 4'b0100, 1'b0};
        vecs[8]  = '{2'd3, 4'b0000, 4'h0, 2'd0, 4'b0001, 1'b0};
        vecs[9]  = '{2'd3, 4'b0000, 4'b1010, 2'd0, 4'b0010, 1'b1};
        vecs[10] = '{2'd1, 4'hF, 4'h0, 2'd3, 4'b0010, 1'b0};
        do_reset();
        for (int i = 0; i < 11; i++) begin
            one_req($sformatf("vec%0d", i), vecs[i].set, vecs[i].vl, vecs[i].hl,
                    vecs[i].mode, vecs[i].line, vecs[i].hit);
        end

        // FIFO: five back-to-back misses on set 2.
        fifo_exp[0] = 4'b0001; fifo_exp[1] = 4'b0010; fifo_exp[2] = 4'b0100;
        fifo_exp[3] = 4'b1000; fifo_exp[4] = 4'b0001;
        @(negedge clk_i);
        req_set_i = 2'd2; req_valid_line_i = 4'hF; req_hit_line_i = 4'h0;
        mode_i = 2'd1; req_valid_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk_i);
            #1;
            if (i == 4) req_valid_i = 1'b0;
            chk($sformatf("fifo%0d_valid", i), int'(resp_valid_o), 1);
            chk($sformatf("fifo%0d_line", i), int'(resp_line_o), int'(fifo_exp[i]));
        end
        @(posedge clk_i);
        #1;
        chk("fifo_end_valid", int'(resp_valid_o), 0);

        // Flush with a request held pending on set 0.
        @(negedge clk_i);
        flush_i = 1'b1;
        req_set_i = 2'd0; req_valid_line_i = 4'hF; req_hit_line_i = 4'h0;
        mode_i = 2'd0; req_valid_i = 1'b1;
        #1;
        chk("flush_req_ready_same_cycle", int'(req_ready_o), 0);
        @(posedge clk_i);
        #1;
        flush_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) begin
                @(posedge clk_i);
                #1;
            end
            chk($sformatf("flush%0d_busy", i), int'(flush_busy_o), 1);
            chk($sformatf("flush%0d_ready", i), int'(req_ready_o), 0);
            chk($sformatf("flush%0d_resp", i), int'(resp_valid_o), 0);
        end
        @(posedge clk_i);
        #1;
        chk("flush_done_busy", int'(flush_busy_o), 0);
        chk("flush_done_ready", int'(req_ready_o), 1);
        chk("flush_done_resp", int'(resp_valid_o), 0);
        @(posedge clk_i);
        #1;
        req_valid_i = 1'b0;
        chk("post_flush_valid", int'(resp_valid_o), 1);
        chk("post_flush_set0_line", int'(resp_line_o), 4'b1000);
        one_req("post_flush_set1", 2'd1, 4'hF, 4'h0, 2'd0, 4'b1000, 1'b0);

        // Reset mid-flush clears busy without a clock edge.
        @(negedge clk_i);
        flush_i = 1'b1;
        @(posedge clk_i);
        #1;
        flush_i = 1'b0;
        @(posedge clk_i);
        #3;
        chk("midflush_busy_before", int'(flush_busy_o), 1);
        rst_ni = 1'b0;
        #1;
        chk("midflush_rst_busy", int'(flush_busy_o), 0);
        chk("midflush_rst_resp", int'(resp_valid_o), 0);
        @(negedge clk_i);
        rst_ni = 1'b1;

        // Reset during a response strobe clears it immediately.
        @(negedge clk_i);
        req_set_i = 2'd0; req_valid_line_i = 4'hF; req_hit_line_i = 4'h0;
        mode_i = 2'd0; req_valid_i = 1'b1;
        @(posedge clk_i);
        #1;
        req_valid_i = 1'b0;
        chk("midresp_valid_before", int'(resp_valid_o), 1);
        chk("midresp_line_before", int'(resp_line_o), 4'b1000);
        rst_ni = 1'b0;
        #1;
        chk("midresp_rst_valid", int'(resp_valid_o), 0);
        chk("midresp_rst_line", int'(resp_line_o), 0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        one_req("after_rst_set0", 2'd0, 4'hF, 4'h0, 2'd0, 4'b1000, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/replace_policy_unit.md
Name: replace_policy_unit

Overview:
- Multi-set, multi-policy victim selector for the set-associative cache; the generalised successor of the single-set LRU controller.
- Holds per-set replacement state for all sets, and selects among LRU, FIFO and pseudo-random policies at run time.
- Sits between the cache tag-compare stage and the line-fill logic.
- Accepts one lookup per cycle via a valid/ready handshake, returns a one-hot line one cycle later, and supports a multi-cycle state flush.

Parameters:
- SET_NUM, 16, number of sets; power of two, >= 2.
- SET_SIZE, 4, ways per set; power of two, >= 2.
- LFSR_SEED, 16'hACE1, reset value of the random-policy LFSR; must be nonzero.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- mode_i  in  2  policy select: 0 = LRU, 1 = FIFO, 2 = random, 3 = treated as LRU.
- req_valid_i  in  1  lookup request valid.
- req_ready_o  out  1  unit can accept a request.
- req_set_i  in  $clog2(SET_NUM)  set index.
- req_valid_line_i  in  SET_SIZE  per-way valid bits of the set.
- req_hit_line_i  in  SET_SIZE  per-way hit bits; zero means miss.
- resp_valid_o  out  1  one-cycle response strobe.
- resp_line_o  out  SET_SIZE  one-hot way to access or replace.
- resp_hit_o  out  1  response corresponds to a hit.
- flush_i  in  1  start a flush of all replacement state.
- flush_busy_o  out  1  flush in progress.

Behaviour:
- Reset (rst_ni low, asynchronous):
  - FSM goes to IDLE.
  - resp_valid_o=0, resp_line_o=0, resp_hit_o=0, flush_busy_o=0.
  - LFSR=LFSR_SEED.
  - Every set: age[w]=w; fifo_ptr=0.
- FSM states: IDLE and FLUSH.
  - req_ready_o = (state==IDLE) & ~flush_i.
  - In IDLE, flush_i=1 moves to FLUSH with flush counter at 0; a request in the same cycle is not accepted.
  - In FLUSH, one set per cycle is restored to reset values, in order 0..SET_NUM-1. After set SET_NUM-1, return to IDLE, so FLUSH lasts exactly SET_NUM cycles.
  - flush_busy_o is high exactly in FLUSH. flush_i is ignored while in FLUSH.
- Acceptance: req_valid_i & req_ready_o at a rising edge. mode_i is sampled in the same cycle.
- Latency: the response is registered. resp_valid_o is high for exactly the cycle after acceptance; resp_line_o and resp_hit_o are valid only in that cycle. Back-to-back requests give back-to-back responses.
- Hit (any bit of req_hit_line_i set):
  - Chosen way = lowest set hit bit.
  - resp_hit_o=1.
- Miss:
  - If any way is invalid, the chosen way is the lowest-index invalid way, in every mode.
  - Otherwise the chosen way depends on mode:
    - LRU: the way with age == SET_SIZE-1.
    - FIFO: fifo_ptr of the set.
    - Random: LFSR[$clog2(SET_SIZE)-1:0], value at the acceptance cycle.
  - resp_hit_o=0.
- State update at acceptance, for the addressed set only, in all modes:
  - LRU ages: ways with age < age[chosen] increment; age[chosen]=0. The ages always remain a permutation of 0..SET_SIZE-1.
  - fifo_ptr: increments, wrapping modulo SET_SIZE, only on a miss with all ways valid whose chosen way equals fifo_ptr. Under LRU or random mode this happens only when the selected victim coincides with fifo_ptr.
- LFSR: Fibonacci, taps x^16+x^14+x^13+x^11+1. Advances every cycle out of reset, in both FSM states.
- Mode changes: never reset state; they take effect on the next accepted request.
- Reset mid-flush or mid-response: all state and outputs return to reset values immediately and the flush is abandoned.
- A hit on a way marked invalid is still treated as a hit; the lowest hit bit wins.

Test Plan:
- LRU miss sequence (SET_SIZE=4, mode 0): after reset, set 0 all-valid miss gives resp_line_o=4'b1000 one cycle later. A second miss gives 4'b0100 (ages now 1,2,3,0).
- LRU hit then miss: set 1 hit 4'b0100 gives resp_line_o=4'b0100, resp_hit_o=1. The next all-valid miss on set 1 gives 4'b1000 (ages 1,2,0,3). Set 0 ages are unchanged.
- Invalid fill: req_valid_line_i=4'b1011 miss in each of modes 0, 1 and 2 gives 4'b0100 every time. req_valid_line_i=4'b0000 gives 4'b0001.
- FIFO: mode 1, set 2 all valid, five back-to-back misses give 0001, 0010, 0100, 1000, 0001. resp_valid_o is high on five consecutive cycles.
- Random: mode 2, request accepted on the first edge after reset release gives the way equal to LFSR_SEED[1:0] (ACE1 gives 4'b0010). A bench reference-model LFSR matches the following requests.
- Flush: after altering sets 0-3 (SET_NUM=4), pulse flush_i. Check:
  - req_ready_o=0 and flush_busy_o=1 for exactly 4 cycles.
  - A request held valid during the flush is accepted in the first IDLE cycle.
  - Set 0 all-valid miss then gives 4'b1000.
  - Asserting rst_ni low mid-flush clears flush_busy_o and resp_valid_o without waiting for a clock edge.
